// File: rtl/fetch_unit.sv
// fetch_unit: PC holder issuing one IMEM request at a time,
// registering the word and presenting it on a valid/ready handshake.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic [15:0] instr_pc_plus2,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        hlt,
  output logic [15:0] pc
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] OUT    = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [15:0] pc_nx;
  logic [15:0] pc_inc;
  logic [15:0] redir_tgt;
  logic        drop;
  logic        drop_nx;
  logic        valid_nx;
  logic        hlt_nx;
  logic        capture;
  logic        run_q;
  logic        in_fetch;
  logic        in_wait;
  logic        in_out;
  logic        in_halt;
  logic        redir;
  logic        accept;
  logic        is_hlt;

  assign in_fetch  = state == FETCH;
  assign in_wait   = state == WAIT;
  assign in_out    = state == OUT;
  assign in_halt   = state == HALTED;
  assign pc_inc    = pc + 16'd2;
  assign redir_tgt = {redirect_pc[15:1], 1'b0};
  assign redir     = redirect_valid & ~in_halt;
  assign accept    = instr_valid & instr_ready;
  assign is_hlt    = instr[15:12] == 4'hF;

  // run_q keeps the request low while reset is held
  assign imem_req  = in_fetch & run_q;
  assign imem_addr = pc;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    drop_nx  = drop;
    valid_nx = instr_valid;
    hlt_nx   = hlt;
    capture  = 1'b0;
    unique case (1'b1)
      in_fetch: begin
        if (run_q) begin
          state_nx = WAIT;
          drop_nx  = redir;
        end
        if (redir)
          pc_nx = redir_tgt;
      end
      in_wait: begin
        if (redir) begin
          pc_nx    = redir_tgt;
          state_nx = imem_valid ? FETCH : WAIT;
          drop_nx  = ~imem_valid;
        end else if (imem_valid) begin
          if (drop) begin
            drop_nx  = 1'b0;
            state_nx = FETCH;
          end else begin
            capture  = 1'b1;
            valid_nx = 1'b1;
            pc_nx    = pc_inc;
            state_nx = OUT;
          end
        end
      end
      in_out: begin
        if (redir) begin
          pc_nx    = redir_tgt;
          valid_nx = 1'b0;
          state_nx = FETCH;
        end else if (accept) begin
          valid_nx = 1'b0;
          if (is_hlt) begin
            state_nx = HALTED;
            hlt_nx   = 1'b1;
          end else begin
            state_nx = FETCH;
          end
        end
      end
      in_halt: begin
        state_nx = HALTED;
      end
      default: begin
        state_nx = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      drop           <= 1'b0;
      run_q          <= 1'b0;
      instr          <= 16'h0000;
      instr_pc       <= 16'h0000;
      instr_pc_plus2 <= 16'h0000;
      instr_valid    <= 1'b0;
      hlt            <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      drop        <= drop_nx;
      run_q       <= 1'b1;
      instr_valid <= valid_nx;
      hlt         <= hlt_nx;
      if (capture) begin
        instr          <= imem_rdata;
        instr_pc       <= pc;
        instr_pc_plus2 <= pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: variable-latency IMEM model plus a stream-level
// reference of which (pc, word) pairs downstream must see.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_valid = 1'b0;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] instr_pc_plus2;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        hlt;
  logic [15:0] pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .instr(instr), .instr_pc(instr_pc),
    .instr_pc_plus2(instr_pc_plus2),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .hlt(hlt), .pc(pc)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  bit lat_rand = 0;
  int pend_cnt = 0;
  logic [15:0] pend_addr = 16'h0000;
  logic [15:0] model_pc = 16'h0000;
  bit model_halt = 0;
  logic [15:0] ovr [logic [15:0]];
  logic [15:0] req_q[$];
  int          req_cyc_q[$];
  logic [15:0] acc_pc_q[$];
  logic [15:0] acc_dat_q[$];
  logic [15:0] acc_p2_q[$];
  int          acc_cyc_q[$];
  int          rise_cyc_q[$];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    if (ovr.exists(a)) return ovr[a];
    w = a * 16'h03F5 + 16'h1357;
    if (w[15:12] == 4'hF) w[15:12] = 4'h7;
    return w;
  endfunction

  task automatic clear_logs();
    req_q.delete(); req_cyc_q.delete();
    acc_pc_q.delete(); acc_dat_q.delete(); acc_p2_q.delete();
    acc_cyc_q.delete(); rise_cyc_q.delete();
  endtask

  task automatic tick();
    bit hold;
    bit prev_valid;
    logic [15:0] snap_i;
    logic [15:0] snap_pc;
    logic [15:0] w;
    if (rst_n) begin
      if (instr_valid && instr_ready && !redirect_valid) begin
        w = mem_word(model_pc);
        total++;
        if (instr_pc !== model_pc || instr !== w ||
            instr_pc_plus2 !== model_pc + 16'd2) begin
          bad++;
          $display("FAIL accept: got pc=%h instr=%h p2=%h need pc=%h instr=%h p2=%h",
                   instr_pc, instr, instr_pc_plus2, model_pc, w, model_pc + 16'd2);
        end
        acc_pc_q.push_back(instr_pc);
        acc_dat_q.push_back(instr);
        acc_p2_q.push_back(instr_pc_plus2);
        acc_cyc_q.push_back(cyc);
        if (w[15:12] == 4'hF) model_halt = 1;
        model_pc = model_pc + 16'd2;
      end
      if (redirect_valid && !model_halt)
        model_pc = {redirect_pc[15:1], 1'b0};
    end
    hold = rst_n && instr_valid && !instr_ready && !redirect_valid;
    prev_valid = rst_n && instr_valid;
    snap_i = instr;
    snap_pc = instr_pc;
    @(posedge clk);
    #1;
    cyc++;
    if (hold) begin
      total++;
      if (instr_valid !== 1'b1 || instr !== snap_i || instr_pc !== snap_pc) begin
        bad++;
        $display("FAIL hold: got v=%b instr=%h pc=%h need v=1 instr=%h pc=%h",
                 instr_valid, instr, instr_pc, snap_i, snap_pc);
      end
    end
    if (rst_n && instr_valid === 1'b1 && !prev_valid) rise_cyc_q.push_back(cyc);
    imem_valid = 1'b0;
    if (!rst_n) begin
      pend_cnt = 0;
    end else if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_valid = 1'b1;
        imem_rdata = mem_word(pend_addr);
      end
    end
    if (rst_n && imem_req === 1'b1) begin
      total++;
      if (model_halt || pend_cnt != 0 || imem_valid || imem_addr !== model_pc) begin
        bad++;
        $display("FAIL request: got addr=%h halted=%0d busy=%0d need addr=%h idle",
                 imem_addr, model_halt, pend_cnt, model_pc);
      end
      req_q.push_back(imem_addr);
      req_cyc_q.push_back(cyc);
      pend_cnt = lat_rand ? int'($urandom_range(1, 4)) : lat;
      pend_addr = imem_addr;
    end
  endtask

  task automatic do_reset(input bit use_redir, input logic [15:0] tgt);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    imem_valid = 1'b0;
    pend_cnt = 0;
    tick();
    tick();
    model_pc = 16'h0000;
    model_halt = 0;
    clear_logs();
    rst_n = 1'b1;
    if (use_redir) begin
      redirect_valid = 1'b1;
      redirect_pc = tgt;
    end
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget, input string tag);
    int k = 0;
    while (acc_pc_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    total++;
    if (acc_pc_q.size() < n) begin
      bad++;
      $display("FAIL %s timeout: got %0d accepts need %0d", tag, acc_pc_q.size(), n);
    end
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int k = 0;
    while (instr_valid !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    total++;
    if (instr_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s valid timeout: got v=%b need 1", tag, instr_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if (instr_valid !== 1'b0 || hlt !== 1'b0 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl: got v=%b hlt=%b req=%b need 0 0 0", instr_valid, hlt, imem_req);
    end
    total++;
    if (instr !== 16'h0 || instr_pc !== 16'h0 || instr_pc_plus2 !== 16'h0) begin
      bad++;
      $display("FAIL reset_data: got %h %h %h need 0 0 0", instr, instr_pc, instr_pc_plus2);
    end
    total++;
    if (pc !== 16'h0000) begin
      bad++;
      $display("FAIL reset_pc: got %h need 0000", pc);
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp_d[3] = '{16'h1234, 16'h5678, 16'h9ABC};
    lat = 1;
    do_reset(0, 16'h0);
    instr_ready = 1'b1;
    wait_acc(3, 40, "basic");
    for (int i = 0; i < 3 && i < acc_pc_q.size(); i++) begin
      total++;
      if (req_q[i] !== 16'(2 * i) || acc_pc_q[i] !== 16'(2 * i) || acc_dat_q[i] !== exp_d[i]) begin
        bad++;
        $display("FAIL basic_word%0d: got req=%h pc=%h d=%h need %h %h %h",
                 i, req_q[i], acc_pc_q[i], acc_dat_q[i], 16'(2 * i), 16'(2 * i), exp_d[i]);
      end
    end
    total++;
    if (pc !== 16'h0006) begin
      bad++;
      $display("FAIL basic_pc: got %h need 0006", pc);
    end
    total++;
    if (rise_cyc_q.size() < 1 || req_cyc_q.size() < 2 ||
        rise_cyc_q[0] != req_cyc_q[0] + 2 || req_cyc_q[1] != req_cyc_q[0] + 3) begin
      bad++;
      $display("FAIL basic_latency: rise/req timing off from first req (need +2, +3)");
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_stall();
    lat = 1;
    do_reset(0, 16'h0);
    wait_valid(20, "stall");
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (instr_valid !== 1'b1 || instr !== 16'h1234 || instr_pc !== 16'h0000 || imem_req !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d: got v=%b i=%h pc=%h req=%b need 1 1234 0000 0",
                 i, instr_valid, instr, instr_pc, imem_req);
      end
    end
    instr_ready = 1'b1;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin
      bad++;
      $display("FAIL stall_release: got req=%b addr=%h need 1 0002", imem_req, imem_addr);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_redirect_wait();
    lat = 3;
    do_reset(0, 16'h0);
    instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0041;
    tick();
    redirect_valid = 1'b0;
    wait_acc(1, 30, "redir_wait");
    total++;
    if (acc_pc_q.size() < 1 || acc_pc_q[0] !== 16'h0040 || req_q.size() < 2 || req_q[1] !== 16'h0040) begin
      bad++;
      $display("FAIL redir_wait: got first accepted pc / second req not 0040 (reqs=%0d)", req_q.size());
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_halt();
    int k = 0;
    ovr[16'h0010] = 16'hF000;
    lat = 2;
    do_reset(1, 16'h0010);
    instr_ready = 1'b1;
    while (hlt !== 1'b1 && k < 30) begin
      tick();
      k++;
    end
    total++;
    if (hlt !== 1'b1 || acc_cyc_q.size() != 1 || acc_cyc_q[0] != cyc - 1) begin
      bad++;
      $display("FAIL halt_rise: got hlt=%b accepts=%0d need hlt=1 the cycle after one accept",
               hlt, acc_cyc_q.size());
    end
    total++;
    if (pc !== 16'h0012) begin
      bad++;
      $display("FAIL halt_pc: got %h need 0012", pc);
    end
    for (int i = 0; i < 20; i++) begin
      redirect_valid = (i == 5);
      redirect_pc = 16'h0200;
      tick();
      total++;
      if (imem_req !== 1'b0) begin
        bad++;
        $display("FAIL halt_noreq%0d: got req=%b need 0", i, imem_req);
      end
    end
    redirect_valid = 1'b0;
    total++;
    if (pc !== 16'h0012 || hlt !== 1'b1) begin
      bad++;
      $display("FAIL halt_frozen: got pc=%h hlt=%b need 0012 1", pc, hlt);
    end
    rst_n = 1'b0;
    tick();
    total++;
    if (hlt !== 1'b0) begin
      bad++;
      $display("FAIL halt_reset: got hlt=%b need 0", hlt);
    end
    do_reset(0, 16'h0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      bad++;
      $display("FAIL halt_restart: got req=%b addr=%h need 1 0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_halt_cancel();
    lat = 1;
    do_reset(1, 16'h0010);
    wait_valid(20, "hcancel");
    total++;
    if (instr !== 16'hF000) begin
      bad++;
      $display("FAIL hcancel_word: got %h need F000", instr);
    end
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0101;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (hlt !== 1'b0 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL hcancel_flush: got hlt=%b v=%b need 0 0", hlt, instr_valid);
    end
    wait_acc(1, 30, "hcancel");
    total++;
    if (acc_pc_q.size() < 1 || acc_pc_q[0] !== 16'h0100 || hlt !== 1'b0) begin
      bad++;
      $display("FAIL hcancel_resume: got hlt=%b need first accept at 0100 with hlt=0", hlt);
    end
    instr_ready = 1'b0;
    ovr.delete(16'h0010);
  endtask

  task automatic test_wrap_reset();
    lat = 1;
    do_reset(1, 16'hFFFF);
    instr_ready = 1'b1;
    wait_acc(2, 30, "wrap");
    total++;
    if (acc_pc_q.size() < 2 || acc_pc_q[0] !== 16'hFFFE || acc_pc_q[1] !== 16'h0000 ||
        acc_p2_q[0] !== 16'h0000 || acc_p2_q[1] !== 16'h0002) begin
      bad++;
      $display("FAIL wrap: need pc FFFE,0000 and plus2 0000,0002");
    end
    lat = 3;
    tick();
    rst_n = 1'b0;
    tick();
    model_pc = 16'h0000;
    model_halt = 0;
    clear_logs();
    rst_n = 1'b1;
    tick();
    imem_valid = 1'b1;
    imem_rdata = 16'hDEAD;
    tick();
    total++;
    if (instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL stale_valid: got v=%b need 0", instr_valid);
    end
    wait_acc(1, 30, "stale");
    total++;
    if (acc_pc_q.size() < 1 || acc_pc_q[0] !== 16'h0000 || acc_dat_q[0] !== 16'h1234) begin
      bad++;
      $display("FAIL stale_restart: need first accept pc=0000 data=1234");
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_random();
    lat_rand = 1;
    do_reset(0, 16'h0);
    for (int i = 0; i < 500; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = 16'($urandom_range(0, 65535));
      tick();
    end
    redirect_valid = 1'b0;
    total++;
    if (acc_pc_q.size() < 20) begin
      bad++;
      $display("FAIL random_progress: got %0d accepts need >=20", acc_pc_q.size());
    end
    lat_rand = 0;
    instr_ready = 1'b0;
  endtask

  initial begin
    ovr[16'h0000] = 16'h1234;
    ovr[16'h0002] = 16'h5678;
    ovr[16'h0004] = 16'h9ABC;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_halt();
    test_halt_cancel();
    test_wrap_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
